// File: rtl/fb_pkg.sv
// Shared types and helpers for the framebuffer line reader.
package fb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } fb_rd_state_t;

  // Address width needed to cover a w x h framebuffer (never less than 1 bit).
  function automatic int addr_width(input int w, input int h);
    int n;
    n = w * h;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_sync2.sv
// Two-entry same-clock FIFO; head entry is presented combinationally from storage.
module fifo_sync2 #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;

  // Pointer and occupancy tracking; reset discards any buffered entries.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign valid = (count != 2'd0);

endmodule

// File: rtl/fb_line_reader.sv
// Framebuffer line reader: fetches one line from the sync-read BRAM port and
// streams colour indices with x coordinates over a valid/ready interface.
module fb_line_reader
  import fb_pkg::*;
#(
  parameter int CORDW  = 16,
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 180,
  parameter int CIDXW  = 4,
  localparam int ADDRW = addr_width(WIDTH, HEIGHT)
) (
  input  logic                    clk_sys,
  input  logic                    rst_sys,
  input  logic                    frame_start,
  input  logic                    line_req,
  output logic                    busy,
  output logic                    overrun,
  output logic                    bram_re,
  output logic [ADDRW-1:0]        bram_addr,
  input  logic [CIDXW-1:0]        bram_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CIDXW-1:0]        out_cidx,
  output logic signed [CORDW-1:0] out_x,
  output logic                    out_last
);

  localparam int XW    = $clog2(WIDTH + 1);
  localparam int LINEW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic signed [CORDW-1:0] X_LAST = CORDW'(WIDTH - 1);
  localparam logic signed [CORDW-1:0] X_ONE  = CORDW'(1);

  fb_rd_state_t     state, state_next;
  logic [XW-1:0]    rd_x;
  logic [ADDRW-1:0] base;
  logic [LINEW-1:0] line_idx;
  logic             frame_pend;
  logic             vld_p1;
  logic [CIDXW-1:0] fifo_dout;
  logic             fifo_valid;
  logic [1:0]       fifo_count;
  logic             pop;
  logic             can_issue;
  logic             line_done;
  logic [2:0]       used;
  logic [2:0]       limit;

  assign pop       = out_valid && out_ready;
  // A same-cycle pop frees an entry at the edge the new read is issued on,
  // which keeps one read per cycle with a 2-entry buffer.
  assign used      = {1'b0, fifo_count} + {2'b00, vld_p1};
  assign limit     = 3'd2 + {2'b00, pop};
  assign can_issue = (used < limit);
  assign line_done = (state == DRAIN) && pop && out_last;
  assign busy      = (state != IDLE);

  // Next-state logic and read-enable generation.
  always_comb begin
    state_next = state;
    bram_re    = 1'b0;
    case (state)
      IDLE: begin
        if (line_req) state_next = FETCH;
      end
      FETCH: begin
        if (can_issue) begin
          bram_re = 1'b1;
          if (rd_x == XW'(WIDTH - 1)) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (line_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_sys) begin
    if (!rst_sys) state <= IDLE;
    else          state <= state_next;
  end

  // Read address, line tracking, frame restart and overrun bookkeeping.
  always_ff @(posedge clk_sys) begin
    if (!rst_sys) begin
      rd_x       <= '0;
      bram_addr  <= '0;
      base       <= '0;
      line_idx   <= '0;
      frame_pend <= 1'b0;
      overrun    <= 1'b0;
      vld_p1     <= 1'b0;
      out_x      <= '0;
    end else begin
      vld_p1 <= bram_re;

      if (state == IDLE && line_req) begin
        rd_x      <= '0;
        bram_addr <= frame_start ? '0 : base;
      end else if (bram_re) begin
        rd_x      <= rd_x + XW'(1);
        bram_addr <= bram_addr + ADDRW'(1);
      end

      if (pop) out_x <= out_last ? '0 : out_x + X_ONE;

      if (frame_start && state == IDLE) begin
        base       <= '0;
        line_idx   <= '0;
        frame_pend <= 1'b0;
      end else if (line_done) begin
        frame_pend <= 1'b0;
        if (frame_pend || frame_start || line_idx == LINEW'(HEIGHT - 1)) begin
          base     <= '0;
          line_idx <= '0;
        end else begin
          base     <= base + ADDRW'(WIDTH);
          line_idx <= line_idx + LINEW'(1);
        end
      end else if (frame_start) begin
        frame_pend <= 1'b1;
      end

      if (line_req && state != IDLE) overrun <= 1'b1;
      else if (frame_start)          overrun <= 1'b0;
    end
  end

  // ---- stage p1: BRAM data lands in the output buffer ----
  fifo_sync2 #(
    .DATA_W(CIDXW)
  ) u_obuf (
    .clk   (clk_sys),
    .rst_n (rst_sys),
    .push  (vld_p1),
    .din   (bram_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .valid (fifo_valid),
    .count (fifo_count)
  );

  // ---- stage p2: buffered pixel presented on the stream ----
  assign out_valid = fifo_valid;
  assign out_cidx  = fifo_valid ? fifo_dout : '0;
  assign out_last  = fifo_valid && (out_x == X_LAST);

endmodule

// File: tb/tb_fb_line_reader.sv
// Self-checking bench for fb_line_reader with a small BRAM and a queue-based pixel model.
module tb_fb_line_reader;

  localparam int CORDW  = 16;
  localparam int WIDTH  = 8;
  localparam int HEIGHT = 3;
  localparam int CIDXW  = 4;
  localparam int ADDRW  = 5;

  logic                    clk_sys = 1'b0;
  logic                    rst_sys;
  logic                    frame_start;
  logic                    line_req;
  logic                    busy;
  logic                    overrun;
  logic                    bram_re;
  logic [ADDRW-1:0]        bram_addr;
  logic [CIDXW-1:0]        bram_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [CIDXW-1:0]        out_cidx;
  logic signed [CORDW-1:0] out_x;
  logic                    out_last;

  always #5 clk_sys = ~clk_sys;

  fb_line_reader #(
    .CORDW (CORDW),
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .CIDXW (CIDXW)
  ) dut (
    .clk_sys    (clk_sys),
    .rst_sys    (rst_sys),
    .frame_start(frame_start),
    .line_req   (line_req),
    .busy       (busy),
    .overrun    (overrun),
    .bram_re    (bram_re),
    .bram_addr  (bram_addr),
    .bram_data  (bram_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_cidx   (out_cidx),
    .out_x      (out_x),
    .out_last   (out_last)
  );

  // BRAM: mem[a] = a[3:0], one-cycle read latency
  logic [CIDXW-1:0] mem [32];
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = i[3:0];
    bram_data = '0;
  end
  always @(posedge clk_sys) if (bram_re) bram_data <= mem[bram_addr];

  typedef struct {
    logic [CIDXW-1:0]        cidx;
    logic signed [CORDW-1:0] x;
    logic                    last;
  } pix_t;

  pix_t exp_q[$];
  pix_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   mline = 0;
  bit   mon_en = 1'b0;
  int   hs_count = 0;
  int   rd_count = 0;
  bit   prev_stall = 1'b0;
  logic [CIDXW-1:0]        prev_cidx;
  logic signed [CORDW-1:0] prev_x;
  logic                    prev_last;

  // Stream monitor: ordering vs. model, stability under stall, buffer capacity
  always @(negedge clk_sys) begin
    if (mon_en) begin
      if (prev_stall) begin
        checks++;
        if (!out_valid || out_cidx !== prev_cidx || out_x !== prev_x || out_last !== prev_last) begin
          errors++;
          $display("FAIL stall_stable got v=%0b c=%0d x=%0d l=%0b want v=1 c=%0d x=%0d l=%0b",
                   out_valid, out_cidx, out_x, out_last, prev_cidx, prev_x, prev_last);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        hs_count++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stream_extra got c=%0d x=%0d want no pixel", out_cidx, out_x);
        end else begin
          mon_e = exp_q.pop_front();
          if (out_cidx !== mon_e.cidx || out_x !== mon_e.x || out_last !== mon_e.last) begin
            errors++;
            $display("FAIL stream_pixel got c=%0d x=%0d l=%0b want c=%0d x=%0d l=%0b",
                     out_cidx, out_x, out_last, mon_e.cidx, mon_e.x, mon_e.last);
          end
        end
      end
      if (bram_re) begin
        checks++;
        rd_count++;
        if (rd_count - hs_count > 2) begin
          errors++;
          $display("FAIL credit outstanding=%0d want <=2", rd_count - hs_count);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_cidx  = out_cidx;
      prev_x     = out_x;
      prev_last  = out_last;
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic clear_model();
    exp_q.delete();
    hs_count   = 0;
    rd_count   = 0;
    prev_stall = 1'b0;
    mline      = 0;
  endtask

  // Pulse line_req (optionally with frame_start) and queue the expected pixels
  task automatic req_line(input bit with_frame);
    pix_t p;
    if (with_frame) mline = 0;
    for (int x = 0; x < WIDTH; x++) begin
      p.cidx = 4'((mline * WIDTH + x) % 16);
      p.x    = 16'(x);
      p.last = (x == WIDTH - 1);
      exp_q.push_back(p);
    end
    mline = (mline + 1) % HEIGHT;
    line_req    = 1'b1;
    frame_start = with_frame;
    tick();
    line_req    = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s_timeout got busy=%0b pending=%0d want idle", name, busy, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_sys = 1'b0; frame_start = 1'b0; line_req = 1'b0; out_ready = 1'b1;
    tick(); tick();
    checks++;
    if ({busy, overrun, bram_re, out_valid, out_last} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000", {busy, overrun, bram_re, out_valid, out_last});
    end
    checks++;
    if (bram_addr !== '0 || out_cidx !== '0 || out_x !== '0) begin
      errors++;
      $display("FAIL reset_data got addr=%0d c=%0d x=%0d want 0", bram_addr, out_cidx, out_x);
    end
    rst_sys = 1'b1;
    clear_model();
    mon_en = 1'b1;
  endtask

  task automatic test_first_line();
    logic [3:0] got, want;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    mline = 0;
    req_line(1'b0);
    for (int k = 1; k <= WIDTH + 4; k++) begin
      got  = {bram_re, out_valid, out_valid && out_last, busy};
      want = {(k <= WIDTH), (k >= 3 && k <= WIDTH + 2), (k == WIDTH + 2), (k <= WIDTH + 2)};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL first_line_timing cycle=%0d got re/v/last/busy=%b want %b", k, got, want);
      end
      tick();
    end
    wait_idle("first_line");
  endtask

  task automatic test_wrap();
    int exp_addr;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    mline = 0;
    for (int i = 0; i < 4; i++) begin
      exp_addr = mline * WIDTH;
      req_line(1'b0);
      checks++;
      if (!bram_re || bram_addr !== 5'(exp_addr)) begin
        errors++;
        $display("FAIL wrap_start line=%0d got re=%0b addr=%0d want re=1 addr=%0d", i, bram_re, bram_addr, exp_addr);
      end
      wait_idle("wrap");
    end
  endtask

  task automatic test_random_ready();
    int h0, n;
    for (int l = 0; l < 2; l++) begin
      h0 = hs_count;
      req_line(1'b0);
      n = 0;
      while ((busy || exp_q.size() != 0) && n < 300) begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
        n++;
      end
      out_ready = 1'b1;
      checks++;
      if (hs_count - h0 !== WIDTH || n >= 300) begin
        errors++;
        $display("FAIL random_ready_count got %0d want %0d", hs_count - h0, WIDTH);
      end
    end
  endtask

  task automatic test_overrun();
    int h0, n;
    h0 = hs_count;
    req_line(1'b0);
    n = 0;
    while (!(out_valid && out_x == 3) && n < 50) begin tick(); n++; end
    line_req = 1'b1; tick(); line_req = 1'b0;
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set got ovr=%0b busy=%0b want 1 1", overrun, busy);
    end
    wait_idle("overrun");
    checks++;
    if (hs_count - h0 !== WIDTH || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_line got pix=%0d ovr=%0b want %0d 1", hs_count - h0, overrun, WIDTH);
    end
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    mline = 0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear got %0b want 0", overrun);
    end
  endtask

  task automatic test_reset_midline();
    int n;
    req_line(1'b0);
    n = 0;
    while (!(out_valid && out_x == 4) && n < 50) begin tick(); n++; end
    mon_en  = 1'b0;
    rst_sys = 1'b0;
    tick();
    checks++;
    if ({busy, overrun, bram_re, out_valid, out_last} !== 5'b0 ||
        bram_addr !== '0 || out_cidx !== '0 || out_x !== '0) begin
      errors++;
      $display("FAIL midline_reset got busy=%0b re=%0b v=%0b addr=%0d c=%0d x=%0d want all 0",
               busy, bram_re, out_valid, bram_addr, out_cidx, out_x);
    end
    rst_sys = 1'b1;
    clear_model();
    mon_en = 1'b1;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    req_line(1'b0);
    checks++;
    if (!bram_re || bram_addr !== '0) begin
      errors++;
      $display("FAIL midline_restart got re=%0b addr=%0d want re=1 addr=0", bram_re, bram_addr);
    end
    wait_idle("restart");
  endtask

  task automatic test_frame_same_cycle();
    req_line(1'b0);
    wait_idle("to_line2");
    req_line(1'b1);
    for (int k = 0; k < WIDTH; k++) begin
      checks++;
      if (!bram_re || bram_addr !== 5'(k)) begin
        errors++;
        $display("FAIL same_cycle_addr k=%0d got re=%0b addr=%0d want re=1 addr=%0d", k, bram_re, bram_addr, k);
      end
      tick();
    end
    wait_idle("same_cycle");
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_wrap();
    test_random_ready();
    test_overrun();
    test_reset_midline();
    test_frame_same_cycle();
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
